// File: rtl/veda_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | veda_mem_pkg : shared types and default sizes for veda_mem_bank      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package veda_mem_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_ADDR_W   = 10;
   localparam int DEF_DEPTH    = 1024;
   localparam int DEF_READ_LAT = 1;

endpackage
`default_nettype wire

// File: rtl/veda_mem_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | veda_mem_port : one word array with byte writes, range check, and    |
// | a 1- or 2-stage read pipeline.                                 rev 1.0|
// +----------------------------------------------------------------------+
module veda_mem_port #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 10,
   parameter int DEPTH    = 1024,
   parameter int READ_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] be_i,
   input  logic                clr_en_i,
   input  logic [ADDR_W-1:0]   clr_addr_i,
   output logic                rsp_valid_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic                oor_o
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              in_range;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  clr_idx;
   logic              rd_acc;
   logic              v1_q;
   logic [DATA_W-1:0] d1_q;

   assign in_range = ({1'b0, addr_i} < LIMIT);
   assign idx      = addr_i[IDX_W-1:0];
   assign clr_idx  = clr_addr_i[IDX_W-1:0];
   assign oor_o    = req_i && !in_range;
   assign rd_acc   = req_i && !we_i;

   // Clear and requests never coincide: the top holds ready low while clearing.
   always_ff @(posedge clk) begin
      if (clr_en_i) begin
         mem_q[clr_idx] <= '0;
      end else if (req_i && we_i && in_range) begin
         for (int b = 0; b < NB; b++) begin
            if (be_i[b]) begin
               mem_q[idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q <= 1'b0;
         d1_q <= '0;
      end else begin
         v1_q <= rd_acc;
         if (rd_acc) begin
            d1_q <= in_range ? mem_q[idx] : '0;
         end
      end
   end

   if (READ_LAT == 2) begin : g_lat2
      logic              v2_q;
      logic [DATA_W-1:0] d2_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            v2_q <= 1'b0;
            d2_q <= '0;
         end else begin
            v2_q <= v1_q;
            if (v1_q) begin
               d2_q <= d1_q;
            end
         end
      end

      assign rsp_valid_o = v2_q;
      assign rdata_o     = d2_q;
   end else begin : g_lat1
      assign rsp_valid_o = v1_q;
      assign rdata_o     = d1_q;
   end

endmodule
`default_nettype wire

// File: rtl/veda_mem_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | veda_mem_bank : split instruction/data memory with DMEM clear on     |
// | reset and sticky out-of-range error.                           rev 1.0|
// +----------------------------------------------------------------------+
module veda_mem_bank
   import veda_mem_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int READ_LAT = DEF_READ_LAT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req_valid,
   input  logic                i_req_we,
   input  logic [ADDR_W-1:0]   i_addr,
   input  logic [DATA_W-1:0]   i_wdata,
   output logic                i_req_ready,
   output logic                i_rsp_valid,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req_valid,
   input  logic                d_req_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_req_ready,
   output logic                d_rsp_valid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                busy,
   output logic                err
);

   if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_bad_lat
      $error("veda_mem_bank: READ_LAT must be 1 or 2");
   end
   if ((DATA_W % 8) != 0) begin : g_bad_width
      $error("veda_mem_bank: DATA_W must be a multiple of 8");
   end
   if (DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
      $error("veda_mem_bank: DEPTH exceeds 2**ADDR_W");
   end

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_e            state_q;
   logic [ADDR_W-1:0] clr_cnt_q;
   logic              busy_q;
   logic              ready_q;
   logic              err_q;
   logic              clr_en;
   logic              i_accept;
   logic              d_accept;
   logic              i_oor;
   logic              d_oor;

   assign clr_en   = (state_q == CLEAR) && !rst;
   assign i_accept = i_req_valid && ready_q && !rst;
   assign d_accept = d_req_valid && ready_q && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
         busy_q    <= 1'b1;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               if (clr_cnt_q == LAST) begin
                  state_q   <= RUN;
                  clr_cnt_q <= '0;
                  busy_q    <= 1'b0;
                  ready_q   <= 1'b1;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 1'b1;
               end
            end
            RUN: state_q <= RUN;
            default: state_q <= CLEAR;
         endcase
         if (i_oor || d_oor) begin
            err_q <= 1'b1;
         end
      end
   end

   assign i_req_ready = ready_q;
   assign d_req_ready = ready_q;
   assign busy        = busy_q;
   assign err         = err_q;

   // The program image survives reset, so IMEM has no clear path.
   veda_mem_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .READ_LAT (READ_LAT)
   ) u_imem (
      .clk         (clk),
      .rst         (rst),
      .req_i       (i_accept),
      .we_i        (i_req_we),
      .addr_i      (i_addr),
      .wdata_i     (i_wdata),
      .be_i        ({(DATA_W/8){1'b1}}),
      .clr_en_i    (1'b0),
      .clr_addr_i  ('0),
      .rsp_valid_o (i_rsp_valid),
      .rdata_o     (i_rdata),
      .oor_o       (i_oor)
   );

   veda_mem_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .READ_LAT (READ_LAT)
   ) u_dmem (
      .clk         (clk),
      .rst         (rst),
      .req_i       (d_accept),
      .we_i        (d_req_we),
      .addr_i      (d_addr),
      .wdata_i     (d_wdata),
      .be_i        (d_be),
      .clr_en_i    (clr_en),
      .clr_addr_i  (clr_cnt_q),
      .rsp_valid_o (d_rsp_valid),
      .rdata_o     (d_rdata),
      .oor_o       (d_oor)
   );

endmodule
`default_nettype wire
